// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the serial shift sequencer.
//   state_e         : controller FSM encodings (IDLE / SHIFT / GAP)
//   MSB_FIRST/LSB_FIRST : bit-order selector values carried on lsb_first/dir
//   gap_cnt_w()     : width of the idle-gap counter for a given GAP
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  // The gap counter holds GAP-1 down to 0; keep at least one bit so the
  // declaration stays legal when GAP is 0 or 1.
  function automatic int gap_cnt_w(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/shift_seq_chain.sv
// Loadable bidirectional shift register feeding the serial line.
//   clk, reset : system clock, synchronous active-low reset
//   load       : capture d_par and the bit order on dir
//   shift_en   : advance one bit toward the output end, zero-filling
//   dir        : bit order for the word being loaded (MSB_FIRST/LSB_FIRST)
//   d_par      : parallel word
//   q_ser      : bit currently at the output end
module shift_seq_chain
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic             dir,
  input  logic [WIDTH-1:0] d_par,
  output logic             q_ser
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dir_q, dir_d;

  always_comb begin
    shreg_d = shreg_q;
    dir_d   = dir_q;
    if (load) begin
      shreg_d = d_par;
      dir_d   = dir;
    end else if (shift_en) begin
      // Zero fill means a fully drained register presents 0 on q_ser,
      // which keeps the serial line quiet between words.
      if (dir_q == LSB_FIRST) shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      else                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_q <= '0;
      dir_q   <= MSB_FIRST;
    end else begin
      shreg_q <= shreg_d;
      dir_q   <= dir_d;
    end
  end

  assign q_ser = (dir_q == LSB_FIRST) ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serializes parallel words from a valid/ready producer onto one serial
// line, flagging the first and last bit of each word and inserting GAP
// idle cycles between words (GAP==0 allows back-to-back words).
//   clk, reset  : system clock, synchronous active-low reset
//   in_valid    : producer offers in_data
//   in_data     : parallel word
//   lsb_first   : bit order, captured with the word (0 = MSB first)
//   in_ready    : a word is accepted on in_valid && in_ready
//   dout        : serial bit (0 when dout_valid is low)
//   dout_valid  : dout carries a payload bit
//   dout_first  : first bit of a word
//   dout_last   : last bit of a word
//   busy        : controller is shifting or in the idle gap
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int GAP   = 2,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             lsb_first,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_first,
  output logic             dout_last,
  output logic             busy
);

  localparam int               GAP_W    = gap_cnt_w(GAP);
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_first_q, dout_first_d;
  logic             dout_last_q, dout_last_d;
  logic             busy_q, busy_d;
  logic             load, shift_en, accept, last_bit;

  assign last_bit = (state_q == ST_SHIFT) && (bitcnt_q == '0);

  // With no gap the last-bit cycle doubles as an accept slot so words can
  // stream without a bubble.
  assign in_ready = reset && ((state_q == ST_IDLE) || ((GAP == 0) && last_bit));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load     = 1'b1;
          bitcnt_d = BIT_LOAD;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bitcnt_q != '0) begin
          shift_en = 1'b1;
          bitcnt_d = bitcnt_q - CNT_W'(1);
        end else if (accept) begin
          load     = 1'b1;
          bitcnt_d = BIT_LOAD;
        end else begin
          // Final shift drains the register so q_ser returns to 0.
          shift_en = 1'b1;
          if (GAP > 0) begin
            state_d  = ST_GAP;
            gapcnt_d = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gapcnt_q == '0) state_d = ST_IDLE;
        else                gapcnt_d = gapcnt_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Flags are computed from the next state so they are registered
    // alongside the bit the shift register will present.
    dout_valid_d = (state_d == ST_SHIFT);
    dout_first_d = load;
    dout_last_d  = (state_d == ST_SHIFT) && (bitcnt_d == '0);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      bitcnt_q     <= '0;
      gapcnt_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_first_q <= 1'b0;
      dout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      gapcnt_q     <= gapcnt_d;
      dout_valid_q <= dout_valid_d;
      dout_first_q <= dout_first_d;
      dout_last_q  <= dout_last_d;
      busy_q       <= busy_d;
    end
  end

  shift_seq_chain #(.WIDTH(WIDTH)) u_chain (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .dir      (lsb_first),
    .d_par    (in_data),
    .q_ser    (dout)
  );

  assign dout_valid = dout_valid_q;
  assign dout_first = dout_first_q;
  assign dout_last  = dout_last_q;
  assign busy       = busy_q;

endmodule
